// File: rtl/imem_pkg.sv
// Shared types and default sizing for the instruction-memory line-fill block.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } state_t;

  localparam int DEF_DEPTH      = 1024;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_LATENCY    = 3;

endpackage

// File: rtl/imem_array.sv
// Word-addressed instruction storage with combinational read.
// Optional synchronous write port enabled by IMEM_WRITE_PORT_EN.
module imem_array
  import imem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int IDX_W = $clog2(DEPTH)
) (
`ifdef IMEM_WRITE_PORT_EN
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
`endif
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [31:0]       rd_data
);

  logic [31:0] mem [DEPTH] = '{default: 32'h0};

`ifdef IMEM_WRITE_PORT_EN
  localparam logic [ADDR_W-3:0] DEPTH_LIM = (ADDR_W-2)'(DEPTH);

  logic [ADDR_W-3:0] wr_word;
  logic              unused_wr_lsb;

  assign wr_word       = wr_addr[ADDR_W-1:2];
  assign unused_wr_lsb = ^wr_addr[1:0];

  // Out-of-range writes are dropped rather than aliased into the array.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_word < DEPTH_LIM)) begin
      mem[wr_word[IDX_W-1:0]] <= wr_data;
    end
  end
`endif

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/imem_line_fill.sv
// Critical-word-first instruction line fill over a ready/valid beat stream.
// Build with IMEM_WRITE_PORT_EN to expose the wr_en/wr_addr/wr_data port.
module imem_line_fill
  import imem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
`ifdef IMEM_WRITE_PORT_EN
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
`endif
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_last,
  output logic              rsp_err
);

  // state | meaning
  // IDLE  | ready for a request, no beat on the response side
  // WAIT  | fixed access latency, wait_q counts down to zero
  // BURST | presenting beats; beat_q counts remaining beats down to zero

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OFF_W = $clog2(LINE_WORDS);

  localparam logic [ADDR_W-3:0] DEPTH_LIM = (ADDR_W-2)'(DEPTH);
  localparam logic [IDX_W-1:0]  OFF_MASK  = IDX_W'(LINE_WORDS-1);
  localparam logic [OFF_W-1:0]  BEAT_INIT = OFF_W'(LINE_WORDS-1);
  localparam logic [3:0]        WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY-1) : 4'd0;

  state_t            state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic [OFF_W-1:0]  beat_q, beat_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [IDX_W-1:0]  base_q, base_d;
  logic              err_q, err_d;

  logic [ADDR_W-3:0] req_word;
  logic [IDX_W-1:0]  rd_idx;
  logic [31:0]       rd_data;
  logic              unused_req_lsb;

  assign req_word       = req_addr[ADDR_W-1:2];
  assign unused_req_lsb = ^req_addr[1:0];

  // base_q keeps its low OFF_W bits clear, so OR-ing in the offset wraps within the line.
  assign rd_idx = base_q | IDX_W'(off_q);

  imem_array #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
`ifdef IMEM_WRITE_PORT_EN
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
`endif
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      beat_q  <= '0;
      off_q   <= '0;
      base_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      beat_q  <= beat_d;
      off_q   <= off_d;
      base_q  <= base_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    beat_d    = beat_q;
    off_d     = off_q;
    base_d    = base_q;
    err_d     = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_last  = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = '0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          base_d  = req_word[IDX_W-1:0] & ~OFF_MASK;
          off_d   = req_word[OFF_W-1:0];
          err_d   = (req_word >= DEPTH_LIM);
          beat_d  = BEAT_INIT;
          wait_d  = WAIT_INIT;
          state_d = (LATENCY > 0) ? WAIT : BURST;
        end
      end
      WAIT: begin
        if (wait_q == 4'd0) begin
          state_d = BURST;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      BURST: begin
        rsp_valid = 1'b1;
        rsp_last  = (beat_q == '0);
        rsp_err   = err_q;
        rsp_data  = err_q ? 32'h0 : rd_data;
        if (rsp_ready) begin
          off_d = off_q + OFF_W'(1);
          if (beat_q == '0) begin
            state_d = IDLE;
          end else begin
            beat_d = beat_q - OFF_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_line_fill.sv
// Scoreboard bench for imem_line_fill: driver queues expected beats, monitor checks them.
module tb_imem_line_fill;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 64;
  localparam int LW     = 4;
  localparam int LAT    = 3;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        err;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;
`ifdef IMEM_WRITE_PORT_EN
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
`endif

  beat_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int beats_seen = 0;
  int acc_count = 0;
  int acc_cyc = -100;
  int last_done_cyc = -100;
  int ready_chk_cyc = -1;
  bit prev_valid = 1'b0;

  imem_line_fill #(
    .ADDR_W     (ADDR_W),
    .DEPTH      (DEPTH),
    .LINE_WORDS (LW),
    .LATENCY    (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef IMEM_WRITE_PORT_EN
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
`endif
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: samples on the falling edge, pops on handshake, checks holds while stalled.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid    = 1'b0;
        ready_chk_cyc = -1;
      end else begin
        if (req_valid && req_ready) begin
          acc_count++;
          acc_cyc = cyc;
        end
        if (cyc == ready_chk_cyc) chk("ready_after_last", 32'(req_ready), 32'd1);
        if (rsp_valid) begin
          chk("ready_busy", 32'(req_ready), 32'd0);
          if (!prev_valid) chk("first_beat_latency", cyc - acc_cyc, LAT + 1);
          if (sb.size() == 0) begin
            chk("beat_unexpected", sb.size(), 32'd1);
          end else begin
            e = sb[0];
            if (rsp_ready) begin
              void'(sb.pop_front());
              chk("beat_data", rsp_data, e.data);
              chk("beat_last", 32'(rsp_last), 32'(e.last));
              chk("beat_err", 32'(rsp_err), 32'(e.err));
              beats_seen++;
              if (e.last) begin
                ready_chk_cyc = cyc + 1;
                last_done_cyc = cyc;
              end
            end else begin
              chk("hold_data", rsp_data, e.data);
              chk("hold_flags", 32'({rsp_last, rsp_err}), 32'({e.last, e.err}));
            end
          end
        end else begin
          chk("idle_data", rsp_data, 32'd0);
          chk("idle_flags", 32'({rsp_last, rsp_err}), 32'd0);
        end
        prev_valid = rsp_valid;
      end
    end
  end

  task automatic push4(input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] d3, input logic err);
    sb.push_back('{data: d0, last: 1'b0, err: err});
    sb.push_back('{data: d1, last: 1'b0, err: err});
    sb.push_back('{data: d2, last: 1'b0, err: err});
    sb.push_back('{data: d3, last: 1'b1, err: err});
  endtask

  task automatic wait_acc(input int n, input string nm);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (acc_count >= n) return;
    end
    chk(nm, acc_count, n);
  endtask

  task automatic wait_beats(input int n, input string nm);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (beats_seen >= n) return;
    end
    chk(nm, beats_seen, n);
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && req_ready && !rsp_valid) return;
    end
    chk(nm, sb.size(), 32'd0);
  endtask

  task automatic request(input logic [31:0] a, input string nm);
    int n;
    n = acc_count + 1;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = a;
    wait_acc(n, nm);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    int b;
    int a;
    #1;
    for (int i = 0; i < DEPTH; i++) dut.u_array.mem[i] = 32'(i) * 32'h11;
    rsp_ready = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_flags", 32'({rsp_last, rsp_err}), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Plain fill, critical word 9 of line 8..11
    push4(32'h99, 32'hAA, 32'hBB, 32'h88, 1'b0);
    request(32'h24, "t1_accept");
    wait_drain("t1_drain");

    // Two-cycle stall on beat 1
    push4(32'h99, 32'hAA, 32'hBB, 32'h88, 1'b0);
    b = beats_seen;
    request(32'h24, "t2_accept");
    wait_beats(b + 1, "t2_beat0");
    @(posedge clk); #1 rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_drain("t2_drain");

    // Out-of-range line
    push4(32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    request(32'h100, "t3_accept");
    wait_drain("t3_drain");

    // Reset during beat 2
    push4(32'h99, 32'hAA, 32'hBB, 32'h88, 1'b0);
    b = beats_seen;
    request(32'h24, "t4_accept");
    wait_beats(b + 2, "t4_beat1");
    @(posedge clk); #1;
    chk("t4_beat2_data", rsp_data, 32'hBB);
    #1 reset = 1'b1;
    #1;
    chk("t4_rst_valid", 32'(rsp_valid), 32'd0);
    chk("t4_rst_data", rsp_data, 32'd0);
    chk("t4_rst_ready", 32'(req_ready), 32'd1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);

    // Data intact after reset
    push4(32'h99, 32'hAA, 32'hBB, 32'h88, 1'b0);
    request(32'h24, "t5_accept");
    wait_drain("t5_drain");

    // req_valid held high across two fills
    push4(32'h99, 32'hAA, 32'hBB, 32'h88, 1'b0);
    push4(32'hCC, 32'hDD, 32'hEE, 32'hFF, 1'b0);
    a = acc_count;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = 32'h24;
    wait_acc(a + 1, "t6_accept1");
    @(posedge clk); #1 req_addr = 32'h30;
    wait_acc(a + 2, "t6_accept2");
    chk("t6_b2b_accept_cycle", acc_cyc, last_done_cyc + 1);
    @(posedge clk); #1 req_valid = 1'b0;
    wait_drain("t6_drain");

`ifdef IMEM_WRITE_PORT_EN
    @(posedge clk); #1;
    wr_en   = 1'b1;
    wr_addr = 32'h28;
    wr_data = 32'hDEADBEEF;
    @(posedge clk); #1 wr_en = 1'b0;
    push4(32'h88, 32'h99, 32'hDEADBEEF, 32'hBB, 1'b0);
    request(32'h20, "t7_accept");
    wait_drain("t7_drain");
`endif

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_line_fill.md
IMEM_LINE_FILL -- requirements
Module: imem_line_fill

Interface
REQ-001 Parameter: ADDR_W, 32, byte-address width.
REQ-002 Parameter: DEPTH, 1024, number of 32-bit words; power of two, at least LINE_WORDS.
REQ-003 Parameter: LINE_WORDS, 4, words per cache line (burst length); power of two, 2..16.
REQ-004 Parameter: LATENCY, 3, wait cycles before the first beat; range 0..15.
REQ-005 Port: clk, input, 1, the single clock; all state changes on the rising edge.
REQ-006 Port: reset, input, 1, asynchronous, active-high reset.
REQ-007 Port: req_valid, input, 1, line-fill request present.
REQ-008 Port: req_ready, output, 1, block can accept a request.
REQ-009 Port: req_addr, input, ADDR_W, byte address of the critical word; bits [1:0] ignored.
REQ-010 Port: rsp_valid, output, 1, current beat valid.
REQ-011 Port: rsp_ready, input, 1, consumer accepts the current beat.
REQ-012 Port: rsp_data, output, 32, beat instruction word.
REQ-013 Port: rsp_last, output, 1, final beat of the line.
REQ-014 Port: rsp_err, output, 1, requested word index is out of range.

Function
REQ-015 FSM states: IDLE, WAIT, BURST.
REQ-016 req_ready = 1 only in IDLE; acceptance = req_valid & req_ready.
REQ-017 On acceptance, latch word index w = req_addr[ADDR_W-1:2], line base b = w with low log2(LINE_WORDS) bits cleared, and critical offset c = w mod LINE_WORDS.
REQ-018 After acceptance, go IDLE->WAIT if LATENCY>0, otherwise IDLE->BURST; WAIT lasts exactly LATENCY cycles, then goes to BURST.
REQ-019 The first beat has rsp_valid=1 exactly LATENCY+1 cycles after the acceptance cycle.
REQ-020 Beat k (0..LINE_WORDS-1) returns word b + ((c+k) mod LINE_WORDS): critical word first, wrapping within the line.
REQ-021 The beat advances only on rsp_valid & rsp_ready; while rsp_ready=0, rsp_data, rsp_last and rsp_err are held stable.
REQ-022 rsp_last = 1 only on beat LINE_WORDS-1; its handshake returns the FSM to IDLE, so req_ready=1 in the next cycle.
REQ-023 If b >= DEPTH, every beat has rsp_err=1 and rsp_data=0; the beat count and timing are unchanged.
REQ-024 rsp_valid = 0 in IDLE and WAIT; rsp_data = 0 whenever rsp_valid = 0.
REQ-025 Memory is initialised to zero at time zero; reads are combinational from the array, indexed by the current beat's word.

Reset
REQ-026 Asserting reset immediately forces IDLE, req_ready=1, and rsp_valid=rsp_last=rsp_err=0, rsp_data=0, and clears the beat and wait counters.
REQ-027 Reset mid-WAIT or mid-BURST aborts the fill with no further beats; memory contents are not altered by reset.

Configuration
REQ-028 Macro IMEM_WRITE_PORT_EN adds input ports wr_en (1), wr_addr (ADDR_W, byte address) and wr_data (32); a word write occurs at the clock edge when wr_en=1 and the index is below DEPTH, otherwise it is ignored.
REQ-029 With IMEM_WRITE_PORT_EN, a beat reading the word being written returns the old value in that cycle and the new value afterwards; without the macro the write ports do not exist and the memory is read-only.

Structure
REQ-030 Shared package imem_pkg holds the state enum (IDLE/WAIT/BURST) and the default constants for DEPTH, LINE_WORDS and LATENCY.
REQ-031 The storage array (with its optional write port) is the sub-module imem_array; the FSM, counters and handshake logic reside in imem_line_fill.

Verification (DEPTH=64, LINE_WORDS=4, LATENCY=3, word i preloaded with i*0x11)
REQ-032 Request req_addr=0x24 with rsp_ready=1 -> rsp_valid first high at cycle 4 after acceptance; data 0x99, 0xAA, 0xBB, 0x88; rsp_last on the 4th beat; req_ready=1 on the next cycle.
REQ-033 Same request with rsp_ready=0 for 2 cycles during beat 1 -> 0xAA held for 3 cycles; no beat skipped or duplicated.
REQ-034 Request req_addr=0x100 -> 4 beats with rsp_err=1 and rsp_data=0, same timing as REQ-032.
REQ-035 Reset pulsed during beat 2 -> rsp_valid=0 the same cycle; after release, a new request to 0x24 returns unchanged data.
REQ-036 req_valid held high throughout a fill -> req_ready=0 in WAIT/BURST; the second request is accepted in the cycle after the rsp_last handshake.
REQ-037 With IMEM_WRITE_PORT_EN: write 0xDEADBEEF to 0x28, then request 0x20 -> beats 0x88, 0x99, 0xDEADBEEF, 0xBB.
